mips_multicycle: RTL and testbench

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_multicycle.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core sharing one memory port for fetch and data.
// Ports: clk/rst, mem_* request/response port, retire/halted/pc_out/mips_out status.
module mips_multicycle #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_out,
   output logic              mips_out
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       imm_q, imm_d;
   logic [31:0]       alu_q, alu_d;
   logic [31:0]       mdr_q, mdr_d;
   logic              zero_q, zero_d;

   logic [31:0] rf_q [32];
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] alu_y;
   logic        alu_ok;
   logic [31:0] pcx, jt;

   assign op    = ir_q[31:26];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign funct = ir_q[5:0];

   // Jump keeps the top nibble of the already-incremented PC.
   assign pcx = 32'(pc_q);
   assign jt  = (pcx & 32'hF000_0000) | {4'b0, ir_q[25:0], 2'b00};

   always_comb begin
      alu_y  = '0;
      alu_ok = 1'b0;
      case (op)
         OP_R: begin
            alu_ok = 1'b1;
            case (funct)
               F_ADD:   alu_y = a_q + b_q;
               F_SUB:   alu_y = a_q - b_q;
               F_AND:   alu_y = a_q & b_q;
               F_OR:    alu_y = a_q | b_q;
               F_SLT:   alu_y = {31'b0, $signed(a_q) < $signed(b_q)};
               default: alu_ok = 1'b0;
            endcase
         end
         OP_ADDI: begin
            alu_ok = 1'b1;
            alu_y  = a_q + imm_q;
         end
         OP_SLTI: begin
            alu_ok = 1'b1;
            alu_y  = {31'b0, $signed(a_q) < $signed(imm_q)};
         end
         OP_ANDI: begin
            alu_ok = 1'b1;
            alu_y  = a_q & imm_q;
         end
         OP_ORI: begin
            alu_ok = 1'b1;
            alu_y  = a_q | imm_q;
         end
         OP_LW, OP_SW: alu_y = a_q + imm_q;
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      zero_d    = zero_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = b_q;
      retire    = 1'b0;
      rf_we     = 1'b0;
      rf_waddr  = (op == OP_R) ? rd : rt;
      rf_wdata  = (op == OP_LW) ? mdr_q : alu_q;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = (rs == 5'd0) ? '0 : rf_q[rs];
            b_d = (rt == 5'd0) ? '0 : rf_q[rt];
            if (op == OP_ANDI || op == OP_ORI)
               imm_d = {16'b0, ir_q[15:0]};
            else
               imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
            state_d = S_EXEC;
         end
         S_EXEC: begin
            alu_d  = alu_y;
            zero_d = (alu_y == '0);
            case (op)
               OP_BEQ: begin
                  zero_d = (a_q == b_q);
                  if (a_q == b_q)
                     pc_d = pc_q + ADDR_W'(imm_q << 2);
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_J: begin
                  pc_d    = jt[ADDR_W-1:0];
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_HALT: begin
                  retire  = 1'b1;
                  state_d = S_HALT;
               end
               OP_LW, OP_SW: state_d = S_MEM;
               default: begin
                  if (alu_ok) begin
                     state_d = S_WB;
                  end else begin
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
               end
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_addr = {alu_q[ADDR_W-1:2], 2'b00};
            mem_we   = (op == OP_SW);
            if (mem_ready) begin
               if (op == OP_SW) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = (rf_waddr != 5'd0);
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
      // Reset suppresses every externally visible action right away.
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         retire  = 1'b0;
         rf_we   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         zero_q  <= zero_d;
      end
   end

   always_ff @(posedge clk) begin
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
      if (rf_we)
         rf_q[rf_waddr] <= rf_wdata;
   end

   assign halted   = (state_q == S_HALT);
   assign pc_out   = pc_q;
   assign mips_out = zero_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: table of ALU programs plus
// hand-written sequences for memory waits, branches, jumps and reset.
module tb_mips_multicycle;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        retire;
   logic        halted;
   logic [31:0] pc_out;
   logic        mips_out;

   mips_multicycle #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .retire   (retire),
      .halted   (halted),
      .pc_out   (pc_out),
      .mips_out (mips_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [128];
   logic [31:0] st_a [$];
   logic [31:0] st_d [$];
   int          nret;
   int          checks;
   int          errors;

   assign mem_rdata = mem[mem_addr[8:2]];

   always @(negedge clk) begin
      if (mem_req && mem_we && mem_ready) begin
         mem[mem_addr[8:2]] = mem_wdata;
         st_a.push_back(mem_addr);
         st_d.push_back(mem_wdata);
      end
      if (retire)
         nret++;
   end

   localparam logic [31:0] HALT = 32'hFC00_0000;

   function automatic logic [31:0] rty(input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d, input logic [5:0] f);
      return {6'h00, s, t, d, 5'h00, f};
   endfunction

   function automatic logic [31:0] ity(input logic [5:0] o, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] im);
      return {o, s, t, im};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++)
         mem[i] = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      nret = 0;
      st_a.delete();
      st_d.delete();
   endtask

   task automatic run_halt(input string nm, input int max);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         step();
         if (halted) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, "_halt"}, 64'(ok), 64'd1);
      step();
   endtask

   typedef struct {
      string       name;
      logic [15:0] i1;
      logic [15:0] i2;
      logic [31:0] ins;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [12];

   initial begin
      int  cyc;
      bit  seen;
      bit  any_req;

      checks    = 0;
      errors    = 0;
      nret      = 0;
      rst       = 1'b1;
      mem_ready = 1'b1;
      clear_mem();

      vt[0]  = '{"add",   16'd5,    16'hFFFD, rty(1, 2, 3, 6'h20), 32'd2};
      vt[1]  = '{"sub",   16'd5,    16'hFFFD, rty(1, 2, 3, 6'h22), 32'd8};
      vt[2]  = '{"and",   16'h00F0, 16'h0FF0, rty(1, 2, 3, 6'h24), 32'h0000_00F0};
      vt[3]  = '{"or",    16'h00F0, 16'h0F00, rty(1, 2, 3, 6'h25), 32'h0000_0FF0};
      vt[4]  = '{"slt_t", 16'hFFFD, 16'd5,    rty(1, 2, 3, 6'h2A), 32'd1};
      vt[5]  = '{"slt_f", 16'd5,    16'hFFFD, rty(1, 2, 3, 6'h2A), 32'd0};
      vt[6]  = '{"addi",  16'd0,    16'd0,    ity(6'h08, 1, 3, 16'hFFFF), 32'hFFFF_FFFF};
      vt[7]  = '{"slti",  16'hFFFB, 16'd0,    ity(6'h0A, 1, 3, 16'hFFFF), 32'd1};
      vt[8]  = '{"andi",  16'hFFFF, 16'd0,    ity(6'h0C, 1, 3, 16'hFFFF), 32'h0000_FFFF};
      vt[9]  = '{"ori",   16'd1,    16'd0,    ity(6'h0D, 1, 3, 16'h8000), 32'h0000_8001};
      vt[10] = '{"wrap",  16'hFFFF, 16'd0,    rty(1, 1, 3, 6'h20), 32'hFFFF_FFFE};
      vt[11] = '{"slti_eq", 16'd5,  16'd0,    ity(6'h0A, 1, 3, 16'd5), 32'd0};

      step();
      step();
      chk("rst_req",    64'(mem_req),  64'd0);
      chk("rst_retire", 64'(retire),   64'd0);
      chk("rst_halted", 64'(halted),   64'd0);
      chk("rst_pc",     64'(pc_out),   64'd0);
      chk("rst_zero",   64'(mips_out), 64'd0);

      for (int v = 0; v < 12; v++) begin
         clear_mem();
         mem[0]  = ity(6'h08, 0, 1, vt[v].i1);
         mem[1]  = ity(6'h08, 0, 2, vt[v].i2);
         mem[2]  = vt[v].ins;
         mem[3]  = ity(6'h2B, 0, 3, 16'h0080);
         mem[4]  = HALT;
         mem[32] = 32'hDEAD_BEEF;
         do_reset();
         run_halt(vt[v].name, 200);
         chk({vt[v].name, "_res"}, 64'(mem[32]), 64'(vt[v].exp));
         chk({vt[v].name, "_ret"}, 64'(nret), 64'd5);
      end

      clear_mem();
      mem[0]  = ity(6'h08, 0, 1, 16'd5);
      mem[1]  = ity(6'h08, 0, 2, 16'hFFFD);
      mem[2]  = rty(1, 2, 3, 6'h20);
      mem[3]  = ity(6'h2B, 0, 3, 16'h0080);
      mem[4]  = HALT;
      do_reset();
      seen = 1'b0;
      cyc  = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (nret == 3) begin
            seen = 1'b1;
            cyc  = i + 1;
            break;
         end
      end
      chk("lat12_seen", 64'(seen), 64'd1);
      chk("lat12_cycles", 64'(cyc), 64'd12);
      run_halt("lat12", 100);
      chk("lat12_res", 64'(mem[32]), 64'd2);

      clear_mem();
      mem[0]  = {6'h02, 26'h10};
      mem[16] = ity(6'h08, 0, 3, 16'd2);
      mem[17] = ity(6'h2B, 0, 3, 16'h0008);
      mem[18] = ity(6'h23, 0, 4, 16'h0008);
      mem[19] = ity(6'h2B, 0, 4, 16'h0084);
      mem[20] = HALT;
      mem[33] = 32'hDEAD_BEEF;
      do_reset();
      run_halt("swlw", 200);
      chk("swlw_cnt", 64'(st_a.size()), 64'd2);
      if (st_a.size() > 0) begin
         chk("sw_addr", 64'(st_a[0]), 64'h8);
         chk("sw_data", 64'(st_d[0]), 64'd2);
      end
      chk("lw_res", 64'(mem[33]), 64'd2);
      chk("swlw_ret", 64'(nret), 64'd6);

      clear_mem();
      mem[0]  = ity(6'h08, 0, 5, 16'd9);
      mem[1]  = ity(6'h2B, 0, 5, 16'h0080);
      mem[2]  = HALT;
      mem[32] = 32'hDEAD_BEEF;
      mem_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("wait_hold", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
      end
      chk("wait_ret", 64'(nret), 64'd0);
      mem_ready = 1'b1;
      run_halt("wait", 100);
      chk("wait_res", 64'(mem[32]), 64'd9);
      chk("wait_nret", 64'(nret), 64'd3);

      clear_mem();
      mem[0] = ity(6'h08, 0, 1, 16'd3);
      mem[1] = ity(6'h08, 0, 2, 16'd4);
      mem[4] = ity(6'h04, 1, 1, 16'hFFFF);
      do_reset();
      for (int i = 0; i < 60 && nret < 5; i++)
         step();
      step();
      chk("beq_t_pc",   64'(pc_out),   64'h10);
      chk("beq_t_zero", 64'(mips_out), 64'd1);

      mem[4] = ity(6'h04, 1, 2, 16'hFFFF);
      mem[5] = HALT;
      do_reset();
      for (int i = 0; i < 60 && nret < 5; i++)
         step();
      step();
      chk("beq_f_pc",   64'(pc_out),   64'h14);
      chk("beq_f_zero", 64'(mips_out), 64'd0);

      clear_mem();
      mem[0]  = {6'h02, 26'h40};
      mem[64] = HALT;
      do_reset();
      for (int i = 0; i < 20 && nret < 1; i++)
         step();
      step();
      chk("j_fetch", {mem_req, mem_addr}, {1'b1, 32'h100});
      run_halt("j", 50);
      any_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (mem_req)
            any_req = 1'b1;
      end
      chk("halt_stay", 64'(halted), 64'd1);
      chk("halt_noreq", 64'(any_req), 64'd0);
      chk("halt_ret", 64'(nret), 64'd2);

      clear_mem();
      mem[0]  = ity(6'h23, 0, 7, 16'h0040);
      mem[16] = 32'h0000_1234;
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mem_req && mem_addr == 32'h40) begin
            mem_ready = 1'b0;
            seen = 1'b1;
            break;
         end
      end
      chk("lwrst_mem", 64'(seen), 64'd1);
      step();
      step();
      chk("lwrst_wait", {mem_req, mem_addr}, {1'b1, 32'h40});
      rst = 1'b1;
      step();
      chk("lwrst_drop", 64'(mem_req), 64'd0);
      mem[0]  = ity(6'h08, 0, 0, 16'd5);
      mem[1]  = ity(6'h2B, 0, 0, 16'h0084);
      mem[2]  = HALT;
      mem[33] = 32'hDEAD_BEEF;
      rst = 1'b0;
      nret = 0;
      mem_ready = 1'b1;
      #1;
      chk("lwrst_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
      run_halt("r0", 100);
      chk("r0_zero", 64'(mem[33]), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
